// File: rtl/tl_lamp_driver.sv
// Lamp driver for the traffic-light controller: decodes the active-road aspect
// into registered lamp drives, checks the G->Y->R->G protocol, and flashes red on fault.
module tl_lamp_driver #(
  parameter logic [15:0] Y_MIN      = 16'd0,
  parameter logic [15:0] FLASH_HALF = 16'd5
) (
  input  logic        clk,
  input  logic        arstN,
  input  logic [2:0]  tl_signal,
  input  logic [1:0]  index,
  input  logic        fault_clr,
  output logic [11:0] lamp,
  output logic        fault,
  output logic [2:0]  fault_code,
  output logic [1:0]  dbg_state
);

  localparam logic [15:0] HALF_EFF = (FLASH_HALF < 16'd2) ? 16'd1 : FLASH_HALF;
  localparam logic [11:0] ALL_RED  = 12'h924;
  localparam logic [2:0]  SIG_G    = 3'b001;
  localparam logic [2:0]  SIG_Y    = 3'b010;
  localparam logic [2:0]  SIG_R    = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  prev_sig_q, prev_sig_d;
  logic [1:0]  prev_idx_q, prev_idx_d;
  logic [15:0] dwell_q, dwell_d;
  logic [11:0] lamp_q, lamp_d;
  logic        fault_q, fault_d;
  logic [2:0]  fault_code_q, fault_code_d;
  logic [15:0] flash_cnt_q, flash_cnt_d;
  logic        flash_on_q, flash_on_d;

  logic        is_onehot;
  logic        r_to_g;
  logic [2:0]  viol_code;
  logic [11:0] run_lamp;

  always_comb begin
    is_onehot = (tl_signal == SIG_G) || (tl_signal == SIG_Y) || (tl_signal == SIG_R);
    r_to_g    = (prev_sig_q == SIG_R) && (tl_signal == SIG_G);
    // Ordered so the lowest-numbered violation wins when several fire together.
    viol_code = 3'd0;
    if (!is_onehot && (tl_signal != 3'b000)) begin
      viol_code = 3'd1;
    end else if (((prev_sig_q == SIG_G) && (tl_signal == SIG_R)) ||
                 ((prev_sig_q == SIG_Y) && (tl_signal == SIG_G)) ||
                 ((prev_sig_q == SIG_R) && (tl_signal == SIG_Y))) begin
      viol_code = 3'd2;
    end else if ((index != prev_idx_q) && !r_to_g) begin
      viol_code = 3'd3;
    end else if ((prev_sig_q == SIG_Y) && (tl_signal == SIG_R) && (dwell_q < Y_MIN)) begin
      viol_code = 3'd4;
    end else if (tl_signal == 3'b000) begin
      viol_code = 3'd5;
    end
  end

  always_comb begin
    run_lamp = ALL_RED;
    for (int r = 0; r < 4; r++) begin
      if (index == r[1:0]) run_lamp[3*r +: 3] = tl_signal;
    end
  end

  // History registers track the raw input stream in every state.
  always_comb begin
    prev_sig_d = tl_signal;
    prev_idx_d = index;
    if (tl_signal != prev_sig_q) begin
      dwell_d = 16'd1;
    end else if (dwell_q != 16'hFFFF) begin
      dwell_d = dwell_q + 16'd1;
    end else begin
      dwell_d = dwell_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    lamp_d       = lamp_q;
    fault_d      = fault_q;
    fault_code_d = fault_code_q;
    flash_cnt_d  = flash_cnt_q;
    flash_on_d   = flash_on_q;
    case (state_q)
      S_IDLE: begin
        lamp_d = ALL_RED;
        if (tl_signal == SIG_G) begin
          state_d = S_RUN;
          lamp_d  = run_lamp;
        end
      end
      S_RUN: begin
        if (viol_code != 3'd0) begin
          state_d      = S_FAULT;
          fault_d      = 1'b1;
          fault_code_d = viol_code;
          flash_cnt_d  = 16'd0;
          flash_on_d   = 1'b1;
          lamp_d       = ALL_RED;
        end else begin
          lamp_d = run_lamp;
        end
      end
      S_FAULT: begin
        if (fault_clr) begin
          state_d      = S_IDLE;
          fault_d      = 1'b0;
          fault_code_d = 3'd0;
          flash_cnt_d  = 16'd0;
          flash_on_d   = 1'b0;
          lamp_d       = ALL_RED;
        end else begin
          if (flash_cnt_q == HALF_EFF - 16'd1) begin
            flash_cnt_d = 16'd0;
            flash_on_d  = !flash_on_q;
          end else begin
            flash_cnt_d = flash_cnt_q + 16'd1;
          end
          lamp_d = flash_on_d ? ALL_RED : 12'h000;
        end
      end
      default: begin
        state_d = S_IDLE;
        lamp_d  = ALL_RED;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arstN) begin
    if (!arstN) begin
      state_q      <= S_IDLE;
      prev_sig_q   <= 3'b000;
      prev_idx_q   <= 2'd0;
      dwell_q      <= 16'd0;
      lamp_q       <= ALL_RED;
      fault_q      <= 1'b0;
      fault_code_q <= 3'd0;
      flash_cnt_q  <= 16'd0;
      flash_on_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_sig_q   <= prev_sig_d;
      prev_idx_q   <= prev_idx_d;
      dwell_q      <= dwell_d;
      lamp_q       <= lamp_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
      flash_cnt_q  <= flash_cnt_d;
      flash_on_q   <= flash_on_d;
    end
  end

  assign lamp       = lamp_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_tl_lamp_driver.sv
// Bench for tl_lamp_driver: directed protocol scenarios plus a randomized aspect
// stream, every cycle compared against a rule-level reference model.
module tb_tl_lamp_driver;

  localparam int Y_MIN_P = 3;
  localparam int FH_P    = 5;

  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Z = 3'b000;

  logic        clk;
  logic        arstN;
  logic [2:0]  tl_signal;
  logic [1:0]  index;
  logic        fault_clr;
  logic [11:0] lamp;
  logic        fault;
  logic [2:0]  fault_code;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  tl_lamp_driver #(.Y_MIN(16'(Y_MIN_P)), .FLASH_HALF(16'(FH_P))) dut (
    .clk        (clk),
    .arstN      (arstN),
    .tl_signal  (tl_signal),
    .index      (index),
    .fault_clr  (fault_clr),
    .lamp       (lamp),
    .fault      (fault),
    .fault_code (fault_code),
    .dbg_state  (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: operating mode, last sampled aspect, and cycles spent in fault.
  typedef enum int { M_IDLE, M_RUN, M_FAULT } mode_e;
  mode_e       m_mode;
  logic [2:0]  m_prev_sig;
  logic [1:0]  m_prev_idx;
  int          m_dwell;
  int          m_age;
  int          m_code;
  logic [2:0]  m_sig;
  logic [1:0]  m_idx;

  task automatic model_reset();
    m_mode = M_IDLE; m_prev_sig = Z; m_prev_idx = 2'd0;
    m_dwell = 0; m_age = 0; m_code = 0; m_sig = Z; m_idx = 2'd0;
  endtask

  task automatic model_edge(input logic [2:0] s, input logic [1:0] i, input logic c);
    int code;
    bit onehot;
    onehot = (s == G) || (s == Y) || (s == R);
    code = 0;
    if (!onehot && s != Z)                                       code = 1;
    else if ((m_prev_sig == G && s == R) || (m_prev_sig == Y && s == G) ||
             (m_prev_sig == R && s == Y))                        code = 2;
    else if (i != m_prev_idx && !(m_prev_sig == R && s == G))    code = 3;
    else if (m_prev_sig == Y && s == R && m_dwell < Y_MIN_P)     code = 4;
    else if (s == Z)                                             code = 5;
    case (m_mode)
      M_IDLE:  if (s == G) begin m_mode = M_RUN; m_sig = s; m_idx = i; end
      M_RUN:   if (code != 0) begin m_mode = M_FAULT; m_code = code; m_age = 0; end
               else begin m_sig = s; m_idx = i; end
      default: if (c) begin m_mode = M_IDLE; m_code = 0; end
               else m_age++;
    endcase
    m_dwell    = (s != m_prev_sig) ? 1 : ((m_dwell < 65535) ? m_dwell + 1 : m_dwell);
    m_prev_sig = s;
    m_prev_idx = i;
  endtask

  function automatic logic [11:0] exp_lamp();
    logic [11:0] l;
    l = 12'h000;
    case (m_mode)
      M_IDLE:  l = 12'h924;
      M_RUN:   for (int r = 0; r < 4; r++) l |= 12'(((r == int'(m_idx)) ? m_sig : R)) << (3 * r);
      default: l = (((m_age / FH_P) % 2) == 0) ? 12'h924 : 12'h000;
    endcase
    return l;
  endfunction

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".lamp"},  lamp, exp_lamp());
    chk({tag, ".fault"}, {11'd0, fault}, {11'd0, (m_mode == M_FAULT)});
    chk({tag, ".code"},  {9'd0, fault_code}, 12'(m_code));
  endtask

  task automatic step(input logic [2:0] s, input logic [1:0] i, input logic c, input string tag);
    tl_signal = s; index = i; fault_clr = c;
    @(posedge clk);
    model_edge(s, i, c);
    @(negedge clk);
    chk_all(tag);
  endtask

  initial begin
    logic [2:0] g_sig;
    logic [1:0] g_idx;
    logic [2:0] rs;
    logic [1:0] ri;
    tl_signal = Z; index = 2'd0; fault_clr = 1'b0;
    arstN = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_all("reset");
    chk("reset.state", {10'd0, dbg_state}, 12'd0);
    arstN = 1'b1;

    // Normal cycle, then 000 while running
    repeat (2) step(Z, 2'd0, 1'b0, "norm.init");
    repeat (4) step(G, 2'd0, 1'b0, "norm.g");
    repeat (3) step(Y, 2'd0, 1'b0, "norm.y");
    repeat (2) step(R, 2'd0, 1'b0, "norm.r");
    step(G, 2'd2, 1'b0, "norm.g2");
    chk("norm.road2_green", lamp, 12'h864);
    step(Y, 2'd2, 1'b0, "norm.y2");
    step(Z, 2'd2, 1'b0, "code5");
    chk("code5.code", {9'd0, fault_code}, 12'd5);
    repeat (12) step(Z, 2'd2, 1'b0, "code5.flash");
    step(Z, 2'd2, 1'b1, "code5.clr");

    // Short yellow
    step(G, 2'd0, 1'b0, "short.g");
    repeat (2) step(Y, 2'd0, 1'b0, "short.y");
    step(R, 2'd0, 1'b0, "short.r");
    chk("short.code", {9'd0, fault_code}, 12'd4);
    for (int k = 0; k < 21; k++) begin
      step(R, 2'd0, 1'b0, "short.flash");
      chk("short.gy_off", lamp & 12'h6DB, 12'h000);
    end
    step(R, 2'd0, 1'b1, "short.clr");

    // Non-one-hot in RUN, then G->R
    step(G, 2'd1, 1'b0, "c1.g");
    step(3'b011, 2'd1, 1'b0, "c1.bad");
    chk("c1.code", {9'd0, fault_code}, 12'd1);
    step(Z, 2'd1, 1'b1, "c1.clr");
    step(G, 2'd1, 1'b0, "c2.g");
    step(R, 2'd1, 1'b0, "c2.bad");
    chk("c2.code", {9'd0, fault_code}, 12'd2);
    step(Z, 2'd1, 1'b1, "c2.clr");

    // Index glitch during G
    repeat (2) step(G, 2'd1, 1'b0, "c3.g");
    for (int k = 0; k < 4; k++) begin
      step(G, 2'd3, 1'b0, "c3.glitch");
      chk("c3.road3_not_green", {11'd0, lamp[9]}, 12'd0);
    end
    chk("c3.code", {9'd0, fault_code}, 12'd3);
    step(Z, 2'd3, 1'b1, "c3.clr");

    // Priority (code 1 beats code 3), clear during flash-off, resume
    step(G, 2'd0, 1'b0, "prio.g");
    step(3'b110, 2'd2, 1'b0, "prio.bad");
    chk("prio.code", {9'd0, fault_code}, 12'd1);
    repeat (6) step(Z, 2'd2, 1'b0, "prio.flash");
    chk("prio.off_phase", lamp, 12'h000);
    step(Z, 2'd2, 1'b1, "prio.clr");
    chk("prio.clr_red", lamp, 12'h924);
    step(G, 2'd2, 1'b0, "prio.resume");
    chk("prio.resume_state", {10'd0, dbg_state}, 12'd1);

    // Async reset in the middle of a flash
    step(Z, 2'd2, 1'b0, "ar.fault");
    repeat (3) step(Z, 2'd2, 1'b0, "ar.flash");
    #2 arstN = 1'b0;
    #1;
    model_reset();
    chk_all("ar.async");
    chk("ar.state", {10'd0, dbg_state}, 12'd0);
    @(negedge clk);
    arstN = 1'b1;
    step(Y, 2'd1, 1'b0, "ar.idle_ignore");
    step(G, 2'd1, 1'b0, "ar.resume");

    // Randomized aspect stream: mostly legal cycles with random dwells and noise
    g_sig = G; g_idx = 2'd1;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        case (g_sig)
          G:       g_sig = Y;
          Y:       g_sig = R;
          default: begin g_sig = G; g_idx = 2'($urandom_range(0, 3)); end
        endcase
      end
      rs = g_sig; ri = g_idx;
      if ($urandom_range(0, 29) == 0) begin
        rs = 3'($urandom_range(0, 7));
        ri = 2'($urandom_range(0, 3));
      end
      step(rs, ri, ($urandom_range(0, 5) == 0), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
